// File: rtl/exec_pipe.sv
// exec_pipe: execute stage with PC, flags, halt and a variable-latency RAM handshake
module exec_pipe #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8,
  parameter int PC_W   = 8
) (
  input  logic              CLK_EX,
  input  logic              RESET_N,
  input  logic              INST_VALID,
  output logic              INST_READY,
  input  logic [3:0]        OP_CODE,
  input  logic [DATA_W-1:0] REG_A,
  input  logic [DATA_W-1:0] REG_B,
  input  logic [IMM_W-1:0]  OP_DATA,
  input  logic [DATA_W-1:0] RAM_OUT,
  input  logic              RAM_ACK,
  output logic [PC_W-1:0]   P_COUNT,
  output logic [DATA_W-1:0] REG_IN,
  output logic              REG_WEN,
  output logic [IMM_W-1:0]  RAM_ADDR,
  output logic [DATA_W-1:0] RAM_IN,
  output logic              RAM_REQ,
  output logic              RAM_WEN,
  output logic              FLAG_EQ,
  output logic              FLAG_C,
  output logic              HALTED
);
  localparam logic [3:0] OP_MOV = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                         OP_OR = 4'h4, OP_SL = 4'h5, OP_SR = 4'h6, OP_SRA = 4'h7,
                         OP_LDL = 4'h8, OP_LDH = 4'h9, OP_CMP = 4'ha, OP_JE = 4'hb,
                         OP_JMP = 4'hc, OP_LD = 4'hd, OP_ST = 4'he, OP_HLT = 4'hf;
  typedef enum logic [1:0] {RUN, MEM, HALT} state_t;
  state_t state;
  logic [DATA_W:0] sum, diff;
  logic [DATA_W-1:0] res;
  logic [PC_W-1:0] pc_inc, tgt;
  assign sum = {1'b0, REG_A} + {1'b0, REG_B};
  assign diff = {1'b0, REG_A} - {1'b0, REG_B};
  assign pc_inc = P_COUNT + PC_W'(1);
  assign tgt = PC_W'(OP_DATA);
  assign INST_READY = state == RUN;
  always_comb begin
    res = REG_B;
    case (OP_CODE)
      OP_ADD: res = sum[DATA_W-1:0];
      OP_SUB: res = diff[DATA_W-1:0];
      OP_AND: res = REG_A & REG_B;
      OP_OR:  res = REG_A | REG_B;
      OP_SL:  res = {REG_A[DATA_W-2:0], 1'b0};
      OP_SR:  res = {1'b0, REG_A[DATA_W-1:1]};
      OP_SRA: res = {REG_A[DATA_W-1], REG_A[DATA_W-1:1]};
      OP_LDL: res = {REG_A[DATA_W-1:IMM_W], OP_DATA};
      OP_LDH: res = {OP_DATA, REG_A[DATA_W-IMM_W-1:0]};
      default: res = REG_B;
    endcase
  end
  always_ff @(posedge CLK_EX) begin
    if (!RESET_N) begin
      state <= RUN;
      P_COUNT <= '0;
      REG_IN <= '0;
      REG_WEN <= 1'b0;
      RAM_ADDR <= '0;
      RAM_IN <= '0;
      RAM_REQ <= 1'b0;
      RAM_WEN <= 1'b0;
      FLAG_EQ <= 1'b0;
      FLAG_C <= 1'b0;
      HALTED <= 1'b0;
    end else begin
      REG_WEN <= 1'b0;
      case (state)
        RUN: if (INST_VALID) begin
          if (OP_CODE <= OP_LDH) begin
            REG_IN <= res;
            REG_WEN <= 1'b1;
          end
          if (OP_CODE == OP_ADD) FLAG_C <= sum[DATA_W];
          if (OP_CODE == OP_SUB) FLAG_C <= diff[DATA_W];
          if (OP_CODE == OP_CMP) FLAG_EQ <= REG_A == REG_B;
          P_COUNT <= (OP_CODE == OP_JE) ? (FLAG_EQ ? tgt : pc_inc) :
                     (OP_CODE == OP_JMP) ? tgt :
                     (OP_CODE == OP_LD || OP_CODE == OP_ST || OP_CODE == OP_HLT) ? P_COUNT : pc_inc;
          if (OP_CODE == OP_LD || OP_CODE == OP_ST) begin
            RAM_ADDR <= OP_DATA;
            RAM_IN <= REG_A;
            RAM_REQ <= 1'b1;
            RAM_WEN <= OP_CODE == OP_ST;
            state <= MEM;
          end
          if (OP_CODE == OP_HLT) begin
            HALTED <= 1'b1;
            state <= HALT;
          end
        end
        MEM: if (RAM_ACK) begin
          // RAM_WEN still distinguishes ST from LD until this edge clears it
          if (!RAM_WEN) begin
            REG_IN <= RAM_OUT;
            REG_WEN <= 1'b1;
          end
          RAM_REQ <= 1'b0;
          RAM_WEN <= 1'b0;
          P_COUNT <= pc_inc;
          state <= RUN;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_pipe.sv
// tb_exec_pipe: table-driven ALU/branch vectors plus hand-written memory, reset and halt sequences
module tb_exec_pipe;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, ready, ack = 1'b0;
  logic [3:0] op = 4'h0;
  logic [15:0] a = '0, b = '0, ram_out = '0, reg_in, ram_in;
  logic [7:0] d = '0, pc, ram_addr;
  logic reg_wen, ram_req, ram_wen, feq, fc, halted;
  int n_chk = 0, n_fail = 0;

  exec_pipe dut (
    .CLK_EX(clk), .RESET_N(rst_n), .INST_VALID(valid), .INST_READY(ready),
    .OP_CODE(op), .REG_A(a), .REG_B(b), .OP_DATA(d), .RAM_OUT(ram_out), .RAM_ACK(ack),
    .P_COUNT(pc), .REG_IN(reg_in), .REG_WEN(reg_wen), .RAM_ADDR(ram_addr), .RAM_IN(ram_in),
    .RAM_REQ(ram_req), .RAM_WEN(ram_wen), .FLAG_EQ(feq), .FLAG_C(fc), .HALTED(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op; logic [15:0] a, b; logic [7:0] d;
    logic [15:0] res; logic wen; logic [7:0] pc; logic c, eq;
  } vec_t;
  vec_t tv[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{4'h9, 16'h63a8, 16'h0001, 8'h23, 16'h23a8, 1'b1, 8'h01, 1'b0, 1'b0};
    tv[1]  = '{4'h8, 16'h63a8, 16'h0001, 8'h07, 16'h6307, 1'b1, 8'h02, 1'b0, 1'b0};
    tv[2]  = '{4'h1, 16'h63a8, 16'h0001, 8'h00, 16'h63a9, 1'b1, 8'h03, 1'b0, 1'b0};
    tv[3]  = '{4'h4, 16'h63a8, 16'h0001, 8'h00, 16'h63a9, 1'b1, 8'h04, 1'b0, 1'b0};
    tv[4]  = '{4'h2, 16'h0000, 16'h0001, 8'h00, 16'hffff, 1'b1, 8'h05, 1'b1, 1'b0};
    tv[5]  = '{4'h1, 16'hffff, 16'h0001, 8'h00, 16'h0000, 1'b1, 8'h06, 1'b1, 1'b0};
    tv[6]  = '{4'h7, 16'h8002, 16'h0000, 8'h00, 16'hc001, 1'b1, 8'h07, 1'b1, 1'b0};
    tv[7]  = '{4'h6, 16'h8002, 16'h0000, 8'h00, 16'h4001, 1'b1, 8'h08, 1'b1, 1'b0};
    tv[8]  = '{4'h5, 16'h8002, 16'h0000, 8'h00, 16'h0004, 1'b1, 8'h09, 1'b1, 1'b0};
    tv[9]  = '{4'h0, 16'h0000, 16'h1234, 8'h00, 16'h1234, 1'b1, 8'h0a, 1'b1, 1'b0};
    tv[10] = '{4'h3, 16'hff0f, 16'h0ff0, 8'h00, 16'h0f00, 1'b1, 8'h0b, 1'b1, 1'b0};
    tv[11] = '{4'ha, 16'h0005, 16'h0005, 8'h00, 16'h0000, 1'b0, 8'h0c, 1'b1, 1'b1};
    tv[12] = '{4'hb, 16'h0000, 16'h0000, 8'h40, 16'h0000, 1'b0, 8'h40, 1'b1, 1'b1};
    tv[13] = '{4'ha, 16'h0005, 16'h0006, 8'h00, 16'h0000, 1'b0, 8'h41, 1'b1, 1'b0};
    tv[14] = '{4'hb, 16'h0000, 16'h0000, 8'h40, 16'h0000, 1'b0, 8'h42, 1'b1, 1'b0};
    tv[15] = '{4'hc, 16'h0000, 16'h0000, 8'hff, 16'h0000, 1'b0, 8'hff, 1'b1, 1'b0};
    tv[16] = '{4'h0, 16'h0000, 16'h0000, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b1, 1'b0};
    tv[17] = '{4'h2, 16'h0005, 16'h0005, 8'h00, 16'h0000, 1'b1, 8'h01, 1'b0, 1'b0};

    step();
    step();
    chk("rst_pc", pc, 0);
    chk("rst_reg_in", reg_in, 0);
    chk("rst_wen", reg_wen, 0);
    chk("rst_req", {ram_req, ram_wen}, 0);
    chk("rst_flags", {feq, fc, halted}, 0);
    chk("rst_ready", ready, 1);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      op = tv[i].op; a = tv[i].a; b = tv[i].b; d = tv[i].d; valid = 1'b1;
      step();
      if (tv[i].wen) chk($sformatf("v%0d_reg_in", i), reg_in, tv[i].res);
      chk($sformatf("v%0d_wen", i), reg_wen, tv[i].wen);
      chk($sformatf("v%0d_pc", i), pc, tv[i].pc);
      chk($sformatf("v%0d_c", i), fc, tv[i].c);
      chk($sformatf("v%0d_eq", i), feq, tv[i].eq);
    end

    valid = 1'b0; op = 4'h0;
    step();
    chk("idle_wen", reg_wen, 0);
    chk("idle_pc", pc, 8'h01);

    op = 4'hd; d = 8'h12; a = 16'h5555; ram_out = 16'h8000; valid = 1'b1;
    step();
    op = 4'h0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ld_req%0d", k), ram_req, 1);
      chk($sformatf("ld_addr%0d", k), ram_addr, 8'h12);
      chk($sformatf("ld_ramwen%0d", k), ram_wen, 0);
      chk($sformatf("ld_ready%0d", k), ready, 0);
      chk($sformatf("ld_wen%0d", k), reg_wen, 0);
      chk($sformatf("ld_pc%0d", k), pc, 8'h01);
      if (k == 2) ack = 1'b1;
      step();
    end
    chk("ld_done_req", ram_req, 0);
    chk("ld_done_reg_in", reg_in, 16'h8000);
    chk("ld_done_wen", reg_wen, 1);
    chk("ld_done_pc", pc, 8'h02);
    chk("ld_done_ready", ready, 1);
    valid = 1'b0; ack = 1'b0;
    step();
    chk("ld_pulse_wen", reg_wen, 0);
    chk("ld_pulse_pc", pc, 8'h02);

    op = 4'he; d = 8'h34; a = 16'h63a8; valid = 1'b1;
    step();
    valid = 1'b0;
    chk("st_req", {ram_req, ram_wen}, 2'b11);
    chk("st_in", ram_in, 16'h63a8);
    chk("st_addr", ram_addr, 8'h34);
    chk("st_wen", reg_wen, 0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("st_done_req", {ram_req, ram_wen}, 0);
    chk("st_done_wen", reg_wen, 0);
    chk("st_done_pc", pc, 8'h03);

    op = 4'hd; d = 8'h12; valid = 1'b1;
    step();
    valid = 1'b0;
    chk("mr_req", ram_req, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_req_clr", ram_req, 0);
    chk("mr_pc", pc, 0);
    chk("mr_ready", ready, 1);

    op = 4'hc; d = 8'h07; valid = 1'b1;
    step();
    chk("jmp7_pc", pc, 8'h07);
    op = 4'hf;
    step();
    chk("hlt_halted", halted, 1);
    chk("hlt_pc", pc, 8'h07);
    chk("hlt_ready", ready, 0);
    op = 4'h0; ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("hold_pc%0d", k), pc, 8'h07);
      chk($sformatf("hold_wen%0d", k), reg_wen, 0);
      chk($sformatf("hold_halted%0d", k), halted, 1);
    end
    valid = 1'b0; ack = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("hr_halted", halted, 0);
    chk("hr_pc", pc, 0);
    chk("hr_ready", ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/exec_pipe.md
Name: exec_pipe

Overview:
Parametrised successor of the 15-instruction execute stage. It executes one decoded instruction per accepted INST_VALID beat. The stage keeps its own program counter, equal and carry flags, and a halt state. LD/ST use a RAM request/acknowledge handshake, so memory latency is variable. It sits between decode/register-file read and register-file write-back / data RAM.

Parameters:
DATA_W, 16, register and RAM data width (must be >= 2*IMM_W).
IMM_W, 8, width of OP_DATA immediate and RAM address.
PC_W, 8, program counter width.

Ports:
CLK_EX  in  1  execute clock, all state on rising edge
RESET_N  in  1  synchronous reset, active-low
INST_VALID  in  1  OP_CODE/REG_A/REG_B/OP_DATA valid this cycle
INST_READY  out  1  stage can accept an instruction (state RUN)
OP_CODE  in  4  opcode: MOV0 ADD1 SUB2 AND3 OR4 SL5 SR6 SRA7 LDL8 LDH9 CMPa JEb JMPc LDd STe HLTf
REG_A  in  DATA_W  operand A (destination register's current value)
REG_B  in  DATA_W  operand B
OP_DATA  in  IMM_W  immediate / jump target / RAM address
RAM_OUT  in  DATA_W  RAM read data, valid with RAM_ACK
RAM_ACK  in  1  RAM completes the pending request
P_COUNT  out  PC_W  program counter
REG_IN  out  DATA_W  write-back data
REG_WEN  out  1  write-back strobe, one-cycle pulse
RAM_ADDR  out  IMM_W  RAM address
RAM_IN  out  DATA_W  RAM write data
RAM_REQ  out  1  RAM request, held until RAM_ACK
RAM_WEN  out  1  write qualifier, high with RAM_REQ for ST
FLAG_EQ  out  1  equal flag
FLAG_C  out  1  carry/borrow flag
HALTED  out  1  stage halted

Behaviour:
- All outputs are registered.
- Reset values when RESET_N=0 at an edge: P_COUNT=0, REG_IN=0, REG_WEN=0, RAM_ADDR=0, RAM_IN=0, RAM_REQ=0, RAM_WEN=0, FLAG_EQ=0, FLAG_C=0, HALTED=0, state=RUN.
- Reset has priority over everything, including mid-MEM and HALT.
- States:
  - RUN: INST_READY=1.
  - MEM: waiting for RAM_ACK, INST_READY=0.
  - HALT: INST_READY=0, HALTED=1.
- RUN with INST_VALID=0: nothing changes except REG_WEN=0.
- RUN with INST_VALID=1, latency 1 cycle. Unless noted, REG_WEN=1 for exactly one cycle and P_COUNT<=P_COUNT+1 mod 2^PC_W.
  - MOV: REG_IN=B.
  - ADD: REG_IN=A+B; FLAG_C=carry out of bit DATA_W-1.
  - SUB: REG_IN=A-B; FLAG_C=(A<B) unsigned borrow.
  - AND: REG_IN=A&B.
  - OR: REG_IN=A|B.
  - SL: REG_IN=A<<1.
  - SR: REG_IN=A>>1 logical.
  - SRA: REG_IN=A>>1 with MSB replicated.
  - LDL: REG_IN = A with bits[IMM_W-1:0] replaced by OP_DATA.
  - LDH: REG_IN = A with bits[DATA_W-1:DATA_W-IMM_W] replaced by OP_DATA.
  - CMP: FLAG_EQ=(A==B); REG_WEN=0.
  - JE: REG_WEN=0. P_COUNT=OP_DATA (zero-extended/truncated to PC_W) if FLAG_EQ, else +1. It uses the registered flag, so a CMP on the previous beat is visible.
  - JMP: REG_WEN=0; P_COUNT=OP_DATA unconditionally.
  - LD/ST: RAM_ADDR=OP_DATA, RAM_REQ=1, RAM_WEN=(ST), RAM_IN=A; go to MEM. P_COUNT and REG_WEN are unchanged.
  - HLT: go to HALT. P_COUNT is not incremented; it stays on the HLT address.
- Flags change only on the listed opcodes; other opcodes leave them unchanged.
- MEM state:
  - RAM_REQ/RAM_WEN/RAM_ADDR/RAM_IN are held stable until the edge on which RAM_ACK=1 is sampled.
  - On that edge: RAM_REQ=0, RAM_WEN=0, P_COUNT+1, return to RUN. For LD, additionally REG_IN=RAM_OUT and REG_WEN=1 for one cycle.
  - RAM_ACK in RUN or HALT is ignored. INST_VALID is ignored in MEM and HALT.
- HALT exits only via reset.
- P_COUNT wraps from 2^PC_W-1 to 0 with no error.

Test Plan:
- Reset, then A=63a8, B=0001, valid: LDH 23 -> REG_IN=23a8. LDL 07 -> REG_IN=6307. ADD -> REG_IN=63a9, FLAG_C=0. OR -> 63a9. Each gives one REG_WEN pulse; P_COUNT 0->4.
- A=0000, B=0001, SUB -> REG_IN=ffff, FLAG_C=1. A=ffff, B=0001, ADD -> REG_IN=0000, FLAG_C=1. SRA with A=8002 -> c001; SR -> 4001.
- CMP A=B=0005, then JE 40 -> P_COUNT=40. CMP A=5, B=6, then JE 40 -> P_COUNT=prev+1. JMP ff, then MOV -> P_COUNT wraps ff->00.
- LD 12, with RAM_OUT=8000 and RAM_ACK raised 3 cycles later: RAM_REQ high 3 cycles, RAM_ADDR=12, RAM_WEN=0, INST_READY=0. Then REG_IN=8000, one REG_WEN pulse, P_COUNT+1 once. ST 34 with A=63a8: RAM_WEN=1, RAM_IN=63a8, no REG_WEN.
- Assert RESET_N=0 while in MEM -> next edge RAM_REQ=0, P_COUNT=0, INST_READY=1.
- HLT at P_COUNT=07 -> HALTED=1 and P_COUNT stays 07 despite further INST_VALID/RAM_ACK; reset clears HALTED.
